// File: rtl/dm_port_arbiter_pkg.sv
// Shared constants and types for the two-port data-memory arbiter.
package dm_arb_pkg;
  localparam int AW_DEF = 11;
  localparam int DW_DEF = 32;

  localparam logic REQ_PIPE = 1'b0;
  localparam logic REQ_DBG  = 1'b1;

  typedef struct packed {
    logic              we;
    logic [AW_DEF-1:0] addr;
    logic [DW_DEF-1:0] wdata;
  } dm_access_t;
endpackage

// File: rtl/dm_port_arbiter_if.sv
// One requester's access/response bundle; master = requester, slave = arbiter.
interface dm_req_if
  import dm_arb_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
);
    logic          req;
    logic          we;
    logic          lock;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          gnt;
    logic          rvalid;
    logic [DW-1:0] rdata;

    modport master (output req, we, lock, addr, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, we, lock, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/dm_port_arbiter_rr2.sv
// Two-way round-robin grant with a bounded lock that lets one requester burst.
module dm_arb_rr2
  import dm_arb_pkg::*;
#(
    parameter int MAX_LOCK = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic [1:0] lock,
    output logic [1:0] gnt
);
    localparam int CW = $clog2(MAX_LOCK + 1);
    localparam logic [CW-1:0] CNT_LIM = CW'(MAX_LOCK - 1);

    logic          last_gnt;
    logic          lock_owner_v;
    logic          lock_owner;
    logic [CW-1:0] lock_cnt;
    logic          win_id;
    logic          win_lock;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        gnt = 2'b00;
        if (rst_n) begin
            if (&req) begin
                if (lock_owner_v) gnt[lock_owner] = 1'b1;
                else if (last_gnt == REQ_PIPE) gnt[REQ_DBG] = 1'b1;
                else gnt[REQ_PIPE] = 1'b1;
            end else begin
                gnt = req;
            end
        end
    end

    assign win_id   = gnt[REQ_DBG];
    assign win_lock = win_id ? lock[REQ_DBG] : lock[REQ_PIPE];

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            last_gnt     <= REQ_DBG;
            lock_owner_v <= 1'b0;
            lock_owner   <= REQ_PIPE;
            lock_cnt     <= '0;
        end else begin
            if (|gnt) last_gnt <= win_id;
            // The lock ages out after MAX_LOCK grants so the other side cannot starve.
            if ((|gnt) && win_lock && (lock_cnt < CNT_LIM)) begin
                lock_owner_v <= 1'b1;
                lock_owner   <= win_id;
                lock_cnt     <= lock_cnt + CW'(1);
            end else begin
                lock_owner_v <= 1'b0;
                lock_cnt     <= '0;
            end
        end
    end
endmodule

// File: rtl/dm_port_arbiter.sv
// Pipeline/debug arbiter in front of a single-port RAM2Kx32 with active-low pins.
// Optional grant/conflict counters are enabled with `define DM_ARB_STATS_EN.
module dm_port_arbiter
  import dm_arb_pkg::*;
#(
    parameter int AW       = AW_DEF,
    parameter int DW       = DW_DEF,
    parameter int MAX_LOCK = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    dm_req_if.slave       p0,
    dm_req_if.slave       p1,
    output logic [AW-1:0] ram_a,
    output logic [DW-1:0] ram_d,
    output logic          ram_cen,
    output logic          ram_wen,
    output logic          ram_oen,
    input  logic [DW-1:0] ram_q
`ifdef DM_ARB_STATS_EN
    ,
    output logic [15:0]   stat_gnt0,
    output logic [15:0]   stat_gnt1,
    output logic [15:0]   stat_conflict
`endif
);
    logic [1:0] gnt;
    logic       rd_pend_v;
    logic       rd_pend_id;
    logic       rvalid_act;

    dm_arb_rr2 #(.MAX_LOCK(MAX_LOCK)) u_rr2 (
        .clk   (clk),
        .rst_n (rst_n),
        .req   ({p1.req, p0.req}),
        .lock  ({p1.lock, p0.lock}),
        .gnt   (gnt)
    );

    assign p0.gnt  = gnt[REQ_PIPE];
    assign p1.gnt  = gnt[REQ_DBG];
    assign ram_cen = ~(|gnt);

    always_comb begin
        ram_a   = '0;
        ram_d   = '0;
        ram_wen = 1'b1;
        if (gnt[REQ_PIPE]) begin
            ram_a   = p0.addr;
            ram_d   = p0.wdata;
            ram_wen = ~p0.we;
        end else if (gnt[REQ_DBG]) begin
            ram_a   = p1.addr;
            ram_d   = p1.wdata;
            ram_wen = ~p1.we;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_pend_v  <= 1'b0;
            rd_pend_id <= REQ_PIPE;
        end else begin
            rd_pend_v  <= (gnt[REQ_PIPE] & ~p0.we) | (gnt[REQ_DBG] & ~p1.we);
            rd_pend_id <= gnt[REQ_DBG];
        end
    end

    // A read granted just before reset must not surface while reset is held.
    assign rvalid_act = rd_pend_v & rst_n;
    assign ram_oen    = ~rvalid_act;
    assign p0.rvalid  = rvalid_act & (rd_pend_id == REQ_PIPE);
    assign p1.rvalid  = rvalid_act & (rd_pend_id == REQ_DBG);
    assign p0.rdata   = p0.rvalid ? ram_q : '0;
    assign p1.rdata   = p1.rvalid ? ram_q : '0;

`ifdef DM_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_gnt0     <= '0;
            stat_gnt1     <= '0;
            stat_conflict <= '0;
        end else begin
            if (gnt[REQ_PIPE] && (stat_gnt0 != 16'hFFFF)) stat_gnt0 <= stat_gnt0 + 16'd1;
            if (gnt[REQ_DBG] && (stat_gnt1 != 16'hFFFF)) stat_gnt1 <= stat_gnt1 + 16'd1;
            if (p0.req && p1.req && (stat_conflict != 16'hFFFF))
                stat_conflict <= stat_conflict + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_dm_port_arbiter.sv
// Directed bench for dm_port_arbiter with a behavioural synchronous RAM2Kx32.
module tb_dm_port_arbiter;
    import dm_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] ram_a;
    logic [31:0] ram_d;
    logic        ram_cen, ram_wen, ram_oen;
    logic [31:0] ram_q;
    logic        ram_init = 1'b1;
    logic [31:0] mem [0:2047];
`ifdef DM_ARB_STATS_EN
    logic [15:0] stat_gnt0, stat_gnt1, stat_conflict;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    dm_req_if #(.AW(11), .DW(32)) p0_if ();
    dm_req_if #(.AW(11), .DW(32)) p1_if ();

    dm_port_arbiter #(.AW(11), .DW(32), .MAX_LOCK(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .p0      (p0_if.slave),
        .p1      (p1_if.slave),
        .ram_a   (ram_a),
        .ram_d   (ram_d),
        .ram_cen (ram_cen),
        .ram_wen (ram_wen),
        .ram_oen (ram_oen),
        .ram_q   (ram_q)
`ifdef DM_ARB_STATS_EN
        ,
        .stat_gnt0     (stat_gnt0),
        .stat_gnt1     (stat_gnt1),
        .stat_conflict (stat_conflict)
`endif
    );

    always #5 clk = ~clk;

    // NOTE: memory contents are never reset; they are preloaded once with a known pattern.
    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 2048; i++) mem[i] <= 32'hA500_0000 | i;
        end else if (!ram_cen) begin
            if (!ram_wen) mem[ram_a] <= ram_d;
            else ram_q <= mem[ram_a];
        end
    end

    function automatic dm_access_t rd(input logic [10:0] a);
        return '{we: 1'b0, addr: a, wdata: 32'h0};
    endfunction

    function automatic dm_access_t wr(input logic [10:0] a, input logic [31:0] d);
        return '{we: 1'b1, addr: a, wdata: d};
    endfunction

    task automatic drive(input logic port, input logic req, input logic lock, input dm_access_t a);
        if (port == REQ_PIPE) begin
            p0_if.req = req; p0_if.lock = lock; p0_if.we = a.we;
            p0_if.addr = a.addr; p0_if.wdata = a.wdata;
        end else begin
            p1_if.req = req; p1_if.lock = lock; p1_if.we = a.we;
            p1_if.addr = a.addr; p1_if.wdata = a.wdata;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic apply_reset();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        drive(REQ_PIPE, 1'b1, 1'b0, rd(11'h001));
        drive(REQ_DBG, 1'b1, 1'b0, rd(11'h002));
        #2;
        if ({p1_if.gnt, p0_if.gnt} !== 2'b00) begin
            $display("FAIL reset_gnt: got %b expected 00", {p1_if.gnt, p0_if.gnt}); n_fail++;
        end
        n_checks++;
        if ({ram_cen, ram_wen, ram_oen} !== 3'b111) begin
            $display("FAIL reset_ram_pins: got %b expected 111", {ram_cen, ram_wen, ram_oen}); n_fail++;
        end
        n_checks++;
        if ({p1_if.rvalid, p0_if.rvalid} !== 2'b00 || p0_if.rdata !== 32'h0 || p1_if.rdata !== 32'h0) begin
            $display("FAIL reset_resp: got rvalid %b rdata %h/%h expected 00 and zero data",
                     {p1_if.rvalid, p0_if.rvalid}, p0_if.rdata, p1_if.rdata); n_fail++;
        end
        n_checks++;
        tick();
        drive(REQ_PIPE, 1'b0, 1'b0, rd(11'h0));
        drive(REQ_DBG, 1'b0, 1'b0, rd(11'h0));
        ram_init = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_single_read();
        tick();
        drive(REQ_PIPE, 1'b1, 1'b0, rd(11'h010));
        #2;
        if ({p1_if.gnt, p0_if.gnt} !== 2'b01) begin
            $display("FAIL single_gnt: got %b expected 01", {p1_if.gnt, p0_if.gnt}); n_fail++;
        end
        n_checks++;
        if (ram_cen !== 1'b0 || ram_wen !== 1'b1 || ram_a !== 11'h010) begin
            $display("FAIL single_ram: got cen %b wen %b a %h expected 0 1 010", ram_cen, ram_wen, ram_a); n_fail++;
        end
        n_checks++;
        tick();
        drive(REQ_PIPE, 1'b0, 1'b0, rd(11'h0));
        #2;
        if (p0_if.rvalid !== 1'b1 || p0_if.rdata !== 32'hA500_0010) begin
            $display("FAIL single_rdata: got rvalid %b rdata %h expected 1 a5000010", p0_if.rvalid, p0_if.rdata); n_fail++;
        end
        n_checks++;
        if (p1_if.rvalid !== 1'b0 || p1_if.rdata !== 32'h0 || ram_oen !== 1'b0) begin
            $display("FAIL single_other: got p1 rvalid %b rdata %h oen %b expected 0 0 0",
                     p1_if.rvalid, p1_if.rdata, ram_oen); n_fail++;
        end
        n_checks++;
        tick();
        #2;
        if (p0_if.rvalid !== 1'b0 || ram_oen !== 1'b1) begin
            $display("FAIL single_idle: got rvalid %b oen %b expected 0 1", p0_if.rvalid, ram_oen); n_fail++;
        end
        n_checks++;
    endtask

    task automatic test_round_robin();
        logic exp_p0;
        apply_reset();
        drive(REQ_PIPE, 1'b1, 1'b0, rd(11'h020));
        drive(REQ_DBG, 1'b1, 1'b0, rd(11'h030));
        for (int k = 0; k < 6; k++) begin
            exp_p0 = ((k % 2) == 0);
            #2;
            if (p0_if.gnt !== exp_p0 || p1_if.gnt !== !exp_p0) begin
                $display("FAIL rr_gnt[%0d]: got p0 %b p1 %b expected p0 %b", k, p0_if.gnt, p1_if.gnt, exp_p0); n_fail++;
            end
            n_checks++;
            if (p0_if.rvalid !== ((k % 2) == 1) || p1_if.rvalid !== (k > 0 && (k % 2) == 0)) begin
                $display("FAIL rr_rvalid[%0d]: got p0 %b p1 %b", k, p0_if.rvalid, p1_if.rvalid); n_fail++;
            end
            n_checks++;
            tick();
        end
    endtask

    task automatic test_write_then_read();
        drive(REQ_PIPE, 1'b0, 1'b0, rd(11'h0));
        drive(REQ_DBG, 1'b1, 1'b0, wr(11'h7FF, 32'hDEAD_BEEF));
        #2;
        if (p1_if.gnt !== 1'b1 || ram_wen !== 1'b0 || ram_a !== 11'h7FF || ram_d !== 32'hDEAD_BEEF) begin
            $display("FAIL wr_issue: got gnt %b wen %b a %h d %h expected 1 0 7ff deadbeef",
                     p1_if.gnt, ram_wen, ram_a, ram_d); n_fail++;
        end
        n_checks++;
        if (p1_if.rvalid !== 1'b1 || p1_if.rdata !== 32'hA500_0030 || ram_oen !== 1'b0) begin
            $display("FAIL wr_overlap_rvalid: got rvalid %b rdata %h oen %b expected 1 a5000030 0",
                     p1_if.rvalid, p1_if.rdata, ram_oen); n_fail++;
        end
        n_checks++;
        tick();
        drive(REQ_DBG, 1'b0, 1'b0, rd(11'h0));
        drive(REQ_PIPE, 1'b1, 1'b0, rd(11'h7FF));
        #2;
        if (p0_if.gnt !== 1'b1 || p1_if.rvalid !== 1'b0) begin
            $display("FAIL rd_after_wr_gnt: got gnt %b p1 rvalid %b expected 1 0", p0_if.gnt, p1_if.rvalid); n_fail++;
        end
        n_checks++;
        tick();
        drive(REQ_PIPE, 1'b0, 1'b0, rd(11'h0));
        #2;
        if (p0_if.rvalid !== 1'b1 || p0_if.rdata !== 32'hDEAD_BEEF) begin
            $display("FAIL rd_after_wr_data: got rvalid %b rdata %h expected 1 deadbeef", p0_if.rvalid, p0_if.rdata); n_fail++;
        end
        n_checks++;
    endtask

    task automatic test_lock();
        tick();
        drive(REQ_PIPE, 1'b1, 1'b0, rd(11'h040));
        drive(REQ_DBG, 1'b1, 1'b1, rd(11'h050));
        for (int c = 1; c <= 9; c++) begin
            #2;
            if ({p1_if.gnt, p0_if.gnt} !== ((c <= 8) ? 2'b10 : 2'b01)) begin
                $display("FAIL lock_gnt[%0d]: got %b expected %b", c, {p1_if.gnt, p0_if.gnt},
                         (c <= 8) ? 2'b10 : 2'b01); n_fail++;
            end
            n_checks++;
            tick();
        end
    endtask

    task automatic test_lock_release();
        #2;
        if ({p1_if.gnt, p0_if.gnt} !== 2'b10) begin
            $display("FAIL release_first: got %b expected 10", {p1_if.gnt, p0_if.gnt}); n_fail++;
        end
        n_checks++;
        tick();
        drive(REQ_DBG, 1'b0, 1'b0, rd(11'h0));
        #2;
        if ({p1_if.gnt, p0_if.gnt} !== 2'b01) begin
            $display("FAIL release_handoff: got %b expected 01", {p1_if.gnt, p0_if.gnt}); n_fail++;
        end
        n_checks++;
        tick();
        drive(REQ_PIPE, 1'b0, 1'b0, rd(11'h0));
    endtask

    task automatic test_reset_mid_read();
        tick();
        drive(REQ_PIPE, 1'b1, 1'b0, rd(11'h010));
        #2;
        if (p0_if.gnt !== 1'b1) begin
            $display("FAIL midrst_gnt: got %b expected 1", p0_if.gnt); n_fail++;
        end
        n_checks++;
        tick();
        drive(REQ_PIPE, 1'b0, 1'b0, rd(11'h0));
        rst_n = 1'b0;
        #2;
        if (p0_if.rvalid !== 1'b0 || ram_oen !== 1'b1 || ram_cen !== 1'b1) begin
            $display("FAIL midrst_drop: got rvalid %b oen %b cen %b expected 0 1 1", p0_if.rvalid, ram_oen, ram_cen); n_fail++;
        end
        n_checks++;
        tick();
        rst_n = 1'b1;
        drive(REQ_PIPE, 1'b1, 1'b0, rd(11'h060));
        drive(REQ_DBG, 1'b1, 1'b0, rd(11'h070));
        #2;
        if ({p1_if.gnt, p0_if.gnt} !== 2'b01 || p0_if.rvalid !== 1'b0) begin
            $display("FAIL midrst_first_conflict: got gnt %b rvalid %b expected 01 0",
                     {p1_if.gnt, p0_if.gnt}, p0_if.rvalid); n_fail++;
        end
        n_checks++;
        tick();
        drive(REQ_PIPE, 1'b0, 1'b0, rd(11'h0));
        drive(REQ_DBG, 1'b0, 1'b0, rd(11'h0));
    endtask

`ifdef DM_ARB_STATS_EN
    task automatic test_stats();
        apply_reset();
        drive(REQ_PIPE, 1'b1, 1'b0, rd(11'h080));
        drive(REQ_DBG, 1'b1, 1'b0, rd(11'h090));
        repeat (10) tick();
        drive(REQ_PIPE, 1'b0, 1'b0, rd(11'h0));
        drive(REQ_DBG, 1'b0, 1'b0, rd(11'h0));
        #2;
        if (stat_conflict !== 16'd10) begin
            $display("FAIL stat_conflict: got %0d expected 10", stat_conflict); n_fail++;
        end
        n_checks++;
        if ((17'(stat_gnt0) + 17'(stat_gnt1)) !== 17'd10 || stat_gnt0 !== 16'd5) begin
            $display("FAIL stat_gnt: got gnt0 %0d gnt1 %0d expected 5 5", stat_gnt0, stat_gnt1); n_fail++;
        end
        n_checks++;
    endtask
`endif

    initial begin
        drive(REQ_PIPE, 1'b0, 1'b0, rd(11'h0));
        drive(REQ_DBG, 1'b0, 1'b0, rd(11'h0));
        repeat (2) tick();
        test_reset();
        test_single_read();
        test_round_robin();
        test_write_then_read();
        test_lock();
        test_lock_release();
        test_reset_mid_read();
`ifdef DM_ARB_STATS_EN
        test_stats();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
